// File: rtl/sky130_fd_io__xres_pulse_drv.sv
// sky130_fd_io__xres_pulse_drv: sequences XRES pad enables and drives checked active-low reset pulses on FILT_IN_H
//   CLK, RESET (sync, active-high)
//   PWR_ON_REQ -> ENABLE_VDDIO / ENABLE_H ordering, PWR_ON_ACK when both are up
//   RST_REQ -> FILT_IN_H low for PULSE_CYCLES, RST_BUSY until GAP ends, RST_DONE strobe
//   XRES_SENSE_N returned pad reset, checked for assertion and release; ERR sticky
//   INP_SEL_H tied high to select the FILT_IN_H path
module sky130_fd_io__xres_pulse_drv #(
  parameter int unsigned PULSE_CYCLES   = 80,
  parameter int unsigned GAP_CYCLES     = 80,
  parameter int unsigned EN_HOLD_CYCLES = 2,
  parameter int unsigned SENSE_TIMEOUT  = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PWR_ON_REQ,
  output logic PWR_ON_ACK,
  input  logic RST_REQ,
  output logic RST_BUSY,
  output logic RST_DONE,
  output logic FILT_IN_H,
  output logic INP_SEL_H,
  output logic ENABLE_H,
  output logic ENABLE_VDDIO,
  input  logic XRES_SENSE_N,
  output logic ERR
);
  typedef enum logic [1:0] {OFF, VDDIO_UP, ON, H_DOWN} en_state_t;
  typedef enum logic [1:0] {IDLE, PULSE, RELEASE, GAP} p_state_t;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(EN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam bit               SENSE_CHK  = PULSE_CYCLES > SENSE_TIMEOUT;
  // counter value seen SENSE_TIMEOUT edges after the falling edge
  localparam logic [CNT_W-1:0] CHK_AT     = SENSE_CHK ? CNT_W'(PULSE_CYCLES - SENSE_TIMEOUT) : '0;
  en_state_t        en_state;
  p_state_t         p_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt;
  logic             sense_s1;
  logic             sense_s2;
  logic             accept;
  assign INP_SEL_H = 1'b1;
  assign accept    = (p_state == IDLE) && RST_REQ && PWR_ON_ACK;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sense_s1 <= 1'b1;
      sense_s2 <= 1'b1;
    end else begin
      sense_s1 <= XRES_SENSE_N;
      sense_s2 <= sense_s1;
    end
  end
  // a request accepted in the same cycle as a power-down keeps the pad up until IDLE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_state     <= OFF;
      hold_cnt     <= '0;
      ENABLE_VDDIO <= 1'b0;
      ENABLE_H     <= 1'b0;
      PWR_ON_ACK   <= 1'b0;
    end else begin
      case (en_state)
        OFF: if (PWR_ON_REQ) begin
          en_state     <= VDDIO_UP;
          ENABLE_VDDIO <= 1'b1;
          hold_cnt     <= HOLD_LOAD;
        end
        VDDIO_UP: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        else if (PWR_ON_REQ) begin
          en_state   <= ON;
          ENABLE_H   <= 1'b1;
          PWR_ON_ACK <= 1'b1;
        end else begin
          en_state <= H_DOWN;
          hold_cnt <= HOLD_LOAD;
        end
        ON: if (!PWR_ON_REQ && p_state == IDLE && !accept) begin
          en_state   <= H_DOWN;
          ENABLE_H   <= 1'b0;
          PWR_ON_ACK <= 1'b0;
          hold_cnt   <= HOLD_LOAD;
        end
        H_DOWN: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        else begin
          en_state     <= OFF;
          ENABLE_VDDIO <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      p_state   <= IDLE;
      cnt       <= '0;
      FILT_IN_H <= 1'b1;
      RST_BUSY  <= 1'b0;
      RST_DONE  <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      RST_DONE <= 1'b0;
      case (p_state)
        IDLE: if (accept) begin
          p_state   <= PULSE;
          FILT_IN_H <= 1'b0;
          RST_BUSY  <= 1'b1;
          cnt       <= PULSE_LOAD;
        end
        PULSE: begin
          if (SENSE_CHK && cnt == CHK_AT && sense_s2) ERR <= 1'b1;
          if (cnt == '0) begin
            p_state   <= RELEASE;
            FILT_IN_H <= 1'b1;
            cnt       <= SENSE_LOAD;
          end else cnt <= cnt - 1'b1;
        end
        RELEASE: if (sense_s2 || cnt == '0) begin
          p_state <= GAP;
          cnt     <= GAP_LOAD;
          ERR     <= ERR | ~sense_s2;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) begin
          p_state  <= IDLE;
          RST_DONE <= 1'b1;
          RST_BUSY <= 1'b0;
        end else cnt <= cnt - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_sky130_fd_io__xres_pulse_drv.sv
// tb_sky130_fd_io__xres_pulse_drv: scoreboard bench for the XRES pulse driver
module tb_sky130_fd_io__xres_pulse_drv;
  localparam int P = 80;
  localparam int G = 80;
  localparam int T = 16;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic PWR_ON_REQ = 1'b0;
  logic RST_REQ = 1'b0;
  logic XRES_SENSE_N;
  logic PWR_ON_ACK, RST_BUSY, RST_DONE, FILT_IN_H, INP_SEL_H, ENABLE_H, ENABLE_VDDIO, ERR;
  int checks = 0;
  int failures = 0;
  int mode = 0;
  int dly = 2;
  int cyc = 0;
  logic [7:0] dl = '1;
  logic errc = 1'b0;
  typedef struct {int width; int total; logic err_p; logic err_f; logic chained;} exp_t;
  exp_t q[$];
  sky130_fd_io__xres_pulse_drv dut (
    .CLK(CLK), .RESET(RESET), .PWR_ON_REQ(PWR_ON_REQ), .PWR_ON_ACK(PWR_ON_ACK),
    .RST_REQ(RST_REQ), .RST_BUSY(RST_BUSY), .RST_DONE(RST_DONE), .FILT_IN_H(FILT_IN_H),
    .INP_SEL_H(INP_SEL_H), .ENABLE_H(ENABLE_H), .ENABLE_VDDIO(ENABLE_VDDIO),
    .XRES_SENSE_N(XRES_SENSE_N), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) dl <= {dl[6:0], FILT_IN_H};
  // pad model: mode 0 loops FILT_IN_H back after dly flops, 1 stuck high, 2 stuck low
  assign XRES_SENSE_N = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : (dly == 0 ? FILT_IN_H : dl[dly-1]);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
  endtask
  // expected pulse timing: sense reaches the checker d+3 edges after a FILT_IN_H edge
  task automatic model(input int m, input int d, input logic chained, output exp_t e);
    logic ep, ef;
    int r;
    ep = (m == 1) || (m == 0 && d + 3 > T);
    ef = (m == 2) || (m == 0 && d + 3 > T);
    r = m == 1 ? 1 : m == 2 ? T : (d + 3 <= T ? d + 3 : T);
    e.width = P;
    e.total = P + r + G;
    e.err_p = errc | ep;
    errc = e.err_p | ef;
    e.err_f = errc;
    e.chained = chained;
  endtask
  int fall_cyc = -1;
  int last_done = -1000;
  logic prev_filt = 1'b1;
  always @(negedge CLK) begin
    if (RESET) begin
      fall_cyc = -1;
      prev_filt = 1'b1;
    end else begin
      if (prev_filt && !FILT_IN_H) begin
        fall_cyc = cyc;
        check("pulse_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("busy_at_fall", RST_BUSY, 1);
          if (q[0].chained) check("chain_gap", cyc - last_done, 1);
        end
      end
      if (!prev_filt && FILT_IN_H && fall_cyc >= 0 && q.size() != 0) check("low_width", cyc - fall_cyc, q[0].width);
      if (fall_cyc >= 0 && cyc == fall_cyc + T && q.size() != 0) check("err_at_timeout", ERR, q[0].err_p);
      if (RST_DONE) begin
        check("done_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("done_latency", cyc - fall_cyc, q[0].total);
          check("err_at_done", ERR, q[0].err_f);
          check("busy_at_done", RST_BUSY, 0);
          void'(q.pop_front());
        end
        last_done = cyc;
        fall_cyc = -1;
      end
      prev_filt = FILT_IN_H;
    end
  end
  task automatic wait_idle();
    int n = 0;
    while ((RST_BUSY || q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    check("idle_timeout", n < 600, 1);
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!RST_DONE && n < 600);
    check("done_timeout", RST_DONE, 1);
  endtask
  task automatic setup(input int m, input int d);
    wait_idle();
    mode = m;
    dly = d;
    repeat (4) tick();
  endtask
  task automatic single(input int m, input int d);
    exp_t e;
    int spur;
    setup(m, d);
    RST_REQ = 1'b1;
    model(m, d, 1'b0, e);
    q.push_back(e);
    tick();
    spur = $urandom_range(0, 100);
    repeat (spur) tick();
    RST_REQ = 1'b0;
  endtask
  task automatic pair(input int m, input int d);
    exp_t e;
    setup(m, d);
    RST_REQ = 1'b1;
    model(m, d, 1'b0, e);
    q.push_back(e);
    model(m, d, 1'b1, e);
    q.push_back(e);
    wait_done();
    tick();
    RST_REQ = 1'b0;
  endtask
  initial begin
    exp_t e;
    repeat (3) tick();
    check("reset_outputs", {FILT_IN_H, INP_SEL_H, ENABLE_H, ENABLE_VDDIO, PWR_ON_ACK, RST_BUSY, RST_DONE, ERR}, 8'b1100_0000);
    RESET = 1'b0;
    PWR_ON_REQ = 1'b1;
    tick();
    check("pwr_up_c1", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b100);
    tick();
    check("pwr_up_c2", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b100);
    tick();
    check("pwr_up_c3", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b111);
    single(0, 2);
    single(1, 0);
    single(0, 2);
    pair(0, 3);
    single(2, 0);
    for (int i = 0; i < 14; i++) begin
      int m = $urandom_range(0, 3);
      int d = $urandom_range(0, 6);
      if (m == 3) m = 0;
      if ($urandom_range(0, 3) == 0) pair(m, d);
      else single(m, d);
    end
    setup(0, 2);
    RST_REQ = 1'b1;
    PWR_ON_REQ = 1'b0;
    model(0, 2, 1'b0, e);
    q.push_back(e);
    tick();
    RST_REQ = 1'b0;
    wait_done();
    check("en_h_held_to_done", {ENABLE_VDDIO, ENABLE_H}, 2'b11);
    tick();
    check("pwr_dn_c1", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b100);
    tick();
    check("pwr_dn_c2", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b100);
    tick();
    check("pwr_dn_c3", {ENABLE_VDDIO, ENABLE_H, PWR_ON_ACK}, 3'b000);
    RST_REQ = 1'b1;
    repeat (5) tick();
    RST_REQ = 1'b0;
    check("req_ignored_unpowered", {FILT_IN_H, RST_BUSY}, 2'b10);
    PWR_ON_REQ = 1'b1;
    repeat (4) tick();
    check("repower_ack", PWR_ON_ACK, 1);
    RST_REQ = 1'b1;
    model(0, 2, 1'b0, e);
    q.push_back(e);
    tick();
    RST_REQ = 1'b0;
    repeat (39) tick();
    check("mid_pulse_low", FILT_IN_H, 0);
    RESET = 1'b1;
    q.delete();
    errc = 1'b0;
    tick();
    check("reset_mid_pulse", {FILT_IN_H, RST_BUSY, ENABLE_H, RST_DONE, ERR}, 5'b10000);
    tick();
    RESET = 1'b0;
    repeat (200) tick();
    check("no_done_after_reset", {FILT_IN_H, RST_BUSY, PWR_ON_ACK}, 3'b101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
